// File: rtl/vga_ball_capture.sv
// Sink-side VGA monitor: recovers the drawn ball's bounding box, centre, radius and line/frame timing health.
// Optional ball pixel area counter is compiled in with `define VGA_CAP_AREA_EN.

module vga_ball_capture #(
  parameter int         H_ACTIVE   = 640,
  parameter int         V_ACTIVE   = 480,
  parameter logic [7:0] RED_THRESH = 8'h80
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        frame_done,
  output logic        ball_found,
  output logic [9:0]  ball_xmin,
  output logic [9:0]  ball_xmax,
  output logic [8:0]  ball_ymin,
  output logic [8:0]  ball_ymax,
  output logic [9:0]  ball_hpos,
  output logic [8:0]  ball_vpos,
  output logic [9:0]  ball_radius,
  output logic        timing_err,
  output logic [18:0] ball_area
);

  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [8:0] V_ACT = 9'(V_ACTIVE);
  localparam logic [9:0] X_SAT = 10'h3FF;
  localparam logic [8:0] Y_SAT = 9'h1FF;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic        clk_q_r, clk_q2_r;
  logic        hs_q_r, hs_q2_r;
  logic        vs_q_r, vs_q2_r;
  logic        blank_q_r;
  logic [7:0]  r_q_r, g_q_r, b_q_r;

  logic        pix_s, hs_fall_s, vs_fall_s;
  logic        act_pix_s, ball_pix_s, line_close_s, report_s;

  logic [9:0]  x_r, x_base_s, x_s;
  logic [8:0]  y_r, y_after_s, y_pix_s, y_s;
  logic        err_acc_r, err_close_s, err_s, frame_err_s;

  logic [9:0]  xmin_r, xmax_r, xmin_i_s, xmax_i_s, xmin_s, xmax_s;
  logic [8:0]  ymin_r, ymax_r, ymin_i_s, ymax_i_s, ymin_s, ymax_s;
  logic        any_r, any_s;

  logic [10:0] hsum_s;
  logic [9:0]  vsum_s;
  logic [9:0]  xspan_s;
  logic [9:0]  hpos_s, radius_s;
  logic [8:0]  vpos_s;

  logic        frame_done_r, found_r, terr_r;
  logic [9:0]  xmin_o_r, xmax_o_r, hpos_o_r, radius_o_r;
  logic [8:0]  ymin_o_r, ymax_o_r, vpos_o_r;

  // Input sampling: stage q feeds all processing, stage q2 only serves edge detection.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_q_r   <= 1'b0;
      clk_q2_r  <= 1'b0;
      hs_q_r    <= 1'b0;
      hs_q2_r   <= 1'b0;
      vs_q_r    <= 1'b0;
      vs_q2_r   <= 1'b0;
      blank_q_r <= 1'b0;
      r_q_r     <= 8'd0;
      g_q_r     <= 8'd0;
      b_q_r     <= 8'd0;
    end else begin
      clk_q_r   <= vga_clk;
      clk_q2_r  <= clk_q_r;
      hs_q_r    <= vga_hs;
      hs_q2_r   <= hs_q_r;
      vs_q_r    <= vga_vs;
      vs_q2_r   <= vs_q_r;
      blank_q_r <= vga_blank_n;
      r_q_r     <= vga_r;
      g_q_r     <= vga_g;
      b_q_r     <= vga_b;
    end
  end

  assign pix_s        = clk_q_r & ~clk_q2_r;
  assign hs_fall_s    = ~hs_q_r & hs_q2_r;
  assign vs_fall_s    = ~vs_q_r & vs_q2_r;
  assign act_pix_s    = pix_s & blank_q_r;
  assign ball_pix_s   = act_pix_s & (r_q_r >= RED_THRESH) & (g_q_r < RED_THRESH) & (b_q_r < RED_THRESH);
  assign line_close_s = hs_fall_s & (x_r != 10'd0);

  // Frame sequencing: the partial frame seen after reset is never reported.
  always_comb begin
    state_s  = state_r;
    report_s = 1'b0;
    case (state_r)
      WAIT_VS: begin
        if (vs_fall_s) state_s = ACTIVE;
        else           state_s = WAIT_VS;
      end
      ACTIVE: begin
        if (vs_fall_s) begin
          state_s  = REPORT;
          report_s = 1'b1;
        end else begin
          state_s  = ACTIVE;
        end
      end
      REPORT:  state_s = ACTIVE;
      default: state_s = WAIT_VS;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) state_r <= WAIT_VS;
    else          state_r <= state_s;
  end

  // Raster counters and bounding-box accumulators; a closing line is settled before the pixel on the same cycle.
  always_comb begin
    x_base_s    = hs_fall_s ? 10'd0 : x_r;
    y_after_s   = (line_close_s && (y_r != Y_SAT)) ? (y_r + 9'd1) : y_r;
    y_pix_s     = vs_fall_s ? 9'd0 : y_after_s;
    x_s         = (act_pix_s && (x_base_s != X_SAT)) ? (x_base_s + 10'd1) : x_base_s;
    y_s         = y_pix_s;
    err_close_s = err_acc_r | (line_close_s & (x_r != H_ACT));
    frame_err_s = err_close_s | (y_after_s != V_ACT);
    err_s       = vs_fall_s ? 1'b0 : err_close_s;

    xmin_i_s = vs_fall_s ? X_SAT : xmin_r;
    xmax_i_s = vs_fall_s ? 10'd0 : xmax_r;
    ymin_i_s = vs_fall_s ? Y_SAT : ymin_r;
    ymax_i_s = vs_fall_s ? 9'd0  : ymax_r;
    any_s    = (vs_fall_s ? 1'b0 : any_r) | ball_pix_s;
    xmin_s   = (ball_pix_s && (x_base_s < xmin_i_s)) ? x_base_s : xmin_i_s;
    xmax_s   = (ball_pix_s && (x_base_s > xmax_i_s)) ? x_base_s : xmax_i_s;
    ymin_s   = (ball_pix_s && (y_pix_s  < ymin_i_s)) ? y_pix_s  : ymin_i_s;
    ymax_s   = (ball_pix_s && (y_pix_s  > ymax_i_s)) ? y_pix_s  : ymax_i_s;
  end

  // Raster counter and accumulator registers.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      x_r       <= 10'd0;
      y_r       <= 9'd0;
      err_acc_r <= 1'b0;
      xmin_r    <= X_SAT;
      xmax_r    <= 10'd0;
      ymin_r    <= Y_SAT;
      ymax_r    <= 9'd0;
      any_r     <= 1'b0;
    end else begin
      x_r       <= x_s;
      y_r       <= y_s;
      err_acc_r <= err_s;
      xmin_r    <= xmin_s;
      xmax_r    <= xmax_s;
      ymin_r    <= ymin_s;
      ymax_r    <= ymax_s;
      any_r     <= any_s;
    end
  end

  // Derived geometry of the closing frame; sums are widened by one bit before halving.
  always_comb begin
    hsum_s   = {1'b0, xmin_r} + {1'b0, xmax_r};
    vsum_s   = {1'b0, ymin_r} + {1'b0, ymax_r};
    xspan_s  = xmax_r - xmin_r;
    hpos_s   = hsum_s[10:1];
    vpos_s   = vsum_s[9:1];
    radius_s = {1'b0, xspan_s[9:1]} + 10'd1;
  end

  // Result registers: loaded once per closed frame, held until the next one.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      frame_done_r <= 1'b0;
      found_r      <= 1'b0;
      terr_r       <= 1'b0;
      xmin_o_r     <= 10'd0;
      xmax_o_r     <= 10'd0;
      ymin_o_r     <= 9'd0;
      ymax_o_r     <= 9'd0;
      hpos_o_r     <= 10'd0;
      vpos_o_r     <= 9'd0;
      radius_o_r   <= 10'd0;
    end else begin
      frame_done_r <= report_s;
      if (report_s) begin
        found_r    <= any_r;
        terr_r     <= frame_err_s;
        xmin_o_r   <= any_r ? xmin_r   : 10'd0;
        xmax_o_r   <= any_r ? xmax_r   : 10'd0;
        ymin_o_r   <= any_r ? ymin_r   : 9'd0;
        ymax_o_r   <= any_r ? ymax_r   : 9'd0;
        hpos_o_r   <= any_r ? hpos_s   : 10'd0;
        vpos_o_r   <= any_r ? vpos_s   : 9'd0;
        radius_o_r <= any_r ? radius_s : 10'd0;
      end else begin
        found_r    <= found_r;
        terr_r     <= terr_r;
        xmin_o_r   <= xmin_o_r;
        xmax_o_r   <= xmax_o_r;
        ymin_o_r   <= ymin_o_r;
        ymax_o_r   <= ymax_o_r;
        hpos_o_r   <= hpos_o_r;
        vpos_o_r   <= vpos_o_r;
        radius_o_r <= radius_o_r;
      end
    end
  end

  assign frame_done  = frame_done_r;
  assign ball_found  = found_r;
  assign timing_err  = terr_r;
  assign ball_xmin   = xmin_o_r;
  assign ball_xmax   = xmax_o_r;
  assign ball_ymin   = ymin_o_r;
  assign ball_ymax   = ymax_o_r;
  assign ball_hpos   = hpos_o_r;
  assign ball_vpos   = vpos_o_r;
  assign ball_radius = radius_o_r;

`ifdef VGA_CAP_AREA_EN
  logic [18:0] area_r;
  logic [18:0] area_o_r;

  // Ball pixel counter, saturating; restarts at each frame boundary.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      area_r <= 19'd0;
    end else if (vs_fall_s) begin
      area_r <= ball_pix_s ? 19'd1 : 19'd0;
    end else if (ball_pix_s && (area_r != 19'h7FFFF)) begin
      area_r <= area_r + 19'd1;
    end else begin
      area_r <= area_r;
    end
  end

  // Reported area register.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n)      area_o_r <= 19'd0;
    else if (report_s) area_o_r <= area_r;
    else               area_o_r <= area_o_r;
  end

  assign ball_area = area_o_r;
`else
  assign ball_area = 19'd0;
`endif

endmodule

// File: tb/tb_vga_ball_capture.sv
// Directed bench for vga_ball_capture on a reduced 32x24 raster; expected reports are queued per frame
// and compared when frame_done fires.

module tb_vga_ball_capture;

  localparam int H = 32;
  localparam int V = 24;

  logic        clk50 = 1'b0;
  logic        reset_n;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        frame_done, ball_found, timing_err;
  logic [9:0]  ball_xmin, ball_xmax, ball_hpos, ball_radius;
  logic [8:0]  ball_ymin, ball_ymax, ball_vpos;
  logic [18:0] ball_area;

  typedef struct {
    int found; int xmin; int xmax; int ymin; int ymax;
    int hpos;  int vpos; int radius; int terr; int area;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   vs_low_cyc = 0;
  int   fd_count = 0;
  logic fd_prev = 1'b0;
  int   fd_before;

  int m_found, m_xmin, m_xmax, m_ymin, m_ymax, m_area, m_lines, m_err;

  vga_ball_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .RED_THRESH(8'h80)) dut (
    .clk50(clk50), .reset_n(reset_n), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_done(frame_done), .ball_found(ball_found), .ball_xmin(ball_xmin), .ball_xmax(ball_xmax),
    .ball_ymin(ball_ymin), .ball_ymax(ball_ymax), .ball_hpos(ball_hpos), .ball_vpos(ball_vpos),
    .ball_radius(ball_radius), .timing_err(timing_err), .ball_area(ball_area)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every frame_done pops one expected report.
  always @(negedge clk50) begin
    if (fd_prev) chk("fd_width", int'(frame_done), 0);
    if (frame_done === 1'b1) begin
      fd_count <= fd_count + 1;
      chk("fd_latency", cyc - vs_low_cyc, 2);
      if (exp_q.size() == 0) begin
        chk("fd_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("found",  int'(ball_found),  e.found);
        chk("xmin",   int'(ball_xmin),   e.xmin);
        chk("xmax",   int'(ball_xmax),   e.xmax);
        chk("ymin",   int'(ball_ymin),   e.ymin);
        chk("ymax",   int'(ball_ymax),   e.ymax);
        chk("hpos",   int'(ball_hpos),   e.hpos);
        chk("vpos",   int'(ball_vpos),   e.vpos);
        chk("radius", int'(ball_radius), e.radius);
        chk("terr",   int'(timing_err),  e.terr);
        chk("area",   int'(ball_area),   e.area);
      end
    end
    fd_prev <= frame_done;
  end

  task automatic drive(input logic c, input logic hs, input logic vs, input logic bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clk50);
    if (vga_vs === 1'b1 && vs === 1'b0) vs_low_cyc = cyc;
    vga_clk = c; vga_hs = hs; vga_vs = vs; vga_blank_n = bl;
    vga_r = r; vga_g = g; vga_b = b;
  endtask

  task automatic pixel(input logic hs, input logic vs, input logic bl,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    drive(1'b0, hs, vs, bl, r, g, b);
    drive(1'b1, hs, vs, bl, r, g, b);
  endtask

  task automatic line_tail(input logic vs);
    for (int i = 0; i < 2; i++) pixel(1'b1, vs, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) pixel(1'b0, vs, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) pixel(1'b1, vs, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic blank_line(input logic vs);
    for (int i = 0; i < H; i++) pixel(1'b1, vs, 1'b0, 8'hFF, 8'h00, 8'h00);
    line_tail(vs);
  endtask

  task automatic model_reset();
    m_found = 0; m_xmin = 1023; m_xmax = 0; m_ymin = 511; m_ymax = 0;
    m_area = 0; m_lines = 0; m_err = 0;
  endtask

  // Ball pixels sit exactly on the colour threshold; background alternates two near-miss colours.
  task automatic act_line(input int y, input int npix, input int cx, input int cy, input int rad);
    for (int x = 0; x < npix; x++) begin
      int dx, dy;
      dx = x - cx;
      dy = y - cy;
      if (dx * dx + dy * dy < rad * rad) begin
        m_found = 1;
        if (x < m_xmin) m_xmin = x;
        if (x > m_xmax) m_xmax = x;
        if (y < m_ymin) m_ymin = y;
        if (y > m_ymax) m_ymax = y;
        m_area++;
        pixel(1'b1, 1'b1, 1'b1, 8'h80, 8'h7F, 8'h00);
      end else if (x % 2 == 1) begin
        pixel(1'b1, 1'b1, 1'b1, 8'hFF, 8'h80, 8'h00);
      end else begin
        pixel(1'b1, 1'b1, 1'b1, 8'h7F, 8'h20, 8'h10);
      end
    end
    if (npix > 0) begin
      m_lines++;
      if (npix != H) m_err = 1;
    end
    line_tail(1'b1);
  endtask

  task automatic mid_reset();
    @(negedge clk50);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_found", int'(ball_found), 0);
    chk("rst_mid_xmin",  int'(ball_xmin),  0);
    chk("rst_mid_terr",  int'(timing_err), 0);
    chk("rst_mid_fd",    int'(frame_done), 0);
    @(negedge clk50);
    reset_n = 1'b1;
  endtask

  task automatic body(input int nlines, input int short_y, input int cx, input int cy,
                      input int rad, input int rst_y);
    for (int y = 0; y < nlines; y++) begin
      if (y == rst_y) mid_reset();
      act_line(y, (y == short_y) ? H - 1 : H, cx, cy, rad);
    end
    blank_line(1'b1);
  endtask

  task automatic vsync(input bit rep);
    exp_t x;
    if (rep) begin
      x.found  = m_found;
      x.xmin   = m_found ? m_xmin : 0;
      x.xmax   = m_found ? m_xmax : 0;
      x.ymin   = m_found ? m_ymin : 0;
      x.ymax   = m_found ? m_ymax : 0;
      x.hpos   = m_found ? (m_xmin + m_xmax) / 2 : 0;
      x.vpos   = m_found ? (m_ymin + m_ymax) / 2 : 0;
      x.radius = m_found ? (m_xmax - m_xmin) / 2 + 1 : 0;
      x.terr   = (m_err != 0 || m_lines != V) ? 1 : 0;
`ifdef VGA_CAP_AREA_EN
      x.area   = m_area;
`else
      x.area   = 0;
`endif
      exp_q.push_back(x);
    end
    blank_line(1'b0);
    model_reset();
    blank_line(1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
    vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
    model_reset();
    repeat (3) @(negedge clk50);
    chk("rst_fd",     int'(frame_done),  0);
    chk("rst_found",  int'(ball_found),  0);
    chk("rst_xmin",   int'(ball_xmin),   0);
    chk("rst_xmax",   int'(ball_xmax),   0);
    chk("rst_ymin",   int'(ball_ymin),   0);
    chk("rst_ymax",   int'(ball_ymax),   0);
    chk("rst_hpos",   int'(ball_hpos),   0);
    chk("rst_vpos",   int'(ball_vpos),   0);
    chk("rst_radius", int'(ball_radius), 0);
    chk("rst_terr",   int'(timing_err),  0);
    chk("rst_area",   int'(ball_area),   0);
    reset_n = 1'b1;
    blank_line(1'b1);
    blank_line(1'b1);

    // Empty frame: nothing may be reported before the second frame boundary.
    vsync(1'b0);
    body(V, -1, 0, 0, 0, -1);
    chk("no_early_fd", fd_count, 0);
    vsync(1'b1);

    // Centred ball.
    body(V, -1, 16, 12, 5, -1);
    vsync(1'b1);
    chk("c_found",  int'(ball_found),  1);
    chk("c_xmin",   int'(ball_xmin),   12);
    chk("c_xmax",   int'(ball_xmax),   20);
    chk("c_ymin",   int'(ball_ymin),   8);
    chk("c_ymax",   int'(ball_ymax),   16);
    chk("c_hpos",   int'(ball_hpos),   16);
    chk("c_vpos",   int'(ball_vpos),   12);
    chk("c_radius", int'(ball_radius), 5);
`ifdef VGA_CAP_AREA_EN
    chk("c_area",   int'(ball_area),   69);
`else
    chk("c_area",   int'(ball_area),   0);
`endif

    // Ball clipped at the top-left corner.
    body(V, -1, 0, 0, 5, -1);
    vsync(1'b1);
    chk("k_xmin", int'(ball_xmin), 0);
    chk("k_ymin", int'(ball_ymin), 0);
    chk("k_xmax", int'(ball_xmax), 4);
    chk("k_ymax", int'(ball_ymax), 4);

    // One short line, then a clean frame, then a frame one line short.
    body(V, 5, 16, 12, 3, -1);
    vsync(1'b1);
    chk("short_line_terr", int'(timing_err), 1);
    body(V, -1, 25, 18, 4, -1);
    vsync(1'b1);
    chk("clean_terr", int'(timing_err), 0);
    body(V - 1, -1, 10, 6, 3, -1);
    vsync(1'b1);
    chk("short_frame_terr", int'(timing_err), 1);

    // Reset mid-frame: that frame and the one it lands in are dropped.
    fd_before = fd_count;
    body(V, -1, 16, 12, 5, 10);
    vsync(1'b0);
    chk("no_fd_after_reset", fd_count, fd_before);
    body(V, -1, 20, 10, 6, -1);
    vsync(1'b1);
    blank_line(1'b1);

    chk("queue_drained", exp_q.size(), 0);
    chk("report_count", fd_count, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
